// File: rtl/captura_digito.sv
// rtl/captura_digito.sv - debounced digit capture for the code-checking FSM (optional macro: FILTRO_BCD_EN)
module captura_digito #(
  parameter int DEBOUNCE_CICLOS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] chaves,
  input  logic       botao,
  output logic [3:0] numero,
  output logic       insere,
  output logic       digitoInvalido
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0] CNT_UM  = CW'(1);

  typedef enum logic [1:0] {
    OCIOSO,
    FILTRANDO_PRESS,
    PRESSIONADO,
    FILTRANDO_SOLTA
  } estado_t;

  logic            botao_meta_q, botao_sinc_q;
  logic [3:0]      chaves_meta_q, chaves_sinc_q;
  estado_t         estado_q, estado_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      numero_q, numero_d;
  logic            insere_q, insere_d;
  logic            aceita;
`ifdef FILTRO_BCD_EN
  logic            invalido_q, invalido_d;
`endif

  // Two-flop synchronizers for the raw asynchronous inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      botao_meta_q  <= 1'b0;
      botao_sinc_q  <= 1'b0;
      chaves_meta_q <= 4'd0;
      chaves_sinc_q <= 4'd0;
    end else begin
      botao_meta_q  <= botao;
      botao_sinc_q  <= botao_meta_q;
      chaves_meta_q <= chaves;
      chaves_sinc_q <= chaves_meta_q;
    end
  end

  // Debounce FSM next state: a level change needs DEBOUNCE_CICLOS consecutive samples
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    aceita   = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (botao_sinc_q) begin
          estado_d = FILTRANDO_PRESS;
          cnt_d    = CNT_UM;
        end else begin
          cnt_d    = '0;
        end
      end
      FILTRANDO_PRESS: begin
        if (!botao_sinc_q) begin
          estado_d = OCIOSO;
          cnt_d    = '0;
        end else if (cnt_q == CNT_FIM) begin
          estado_d = PRESSIONADO;
          cnt_d    = '0;
          aceita   = 1'b1;
        end else begin
          cnt_d    = cnt_q + CNT_UM;
        end
      end
      PRESSIONADO: begin
        if (!botao_sinc_q) begin
          estado_d = FILTRANDO_SOLTA;
          cnt_d    = CNT_UM;
        end
      end
      FILTRANDO_SOLTA: begin
        if (botao_sinc_q) begin
          // release bounce: fall back to held without a new pulse
          estado_d = PRESSIONADO;
          cnt_d    = '0;
        end else if (cnt_q == CNT_FIM) begin
          estado_d = OCIOSO;
          cnt_d    = '0;
        end else begin
          cnt_d    = cnt_q + CNT_UM;
        end
      end
      default: begin
        estado_d = FILTRANDO_SOLTA;
        cnt_d    = '0;
      end
    endcase
  end

  // Output next values: pulses only on the acceptance cycle, digit held otherwise
  always_comb begin
    numero_d   = numero_q;
    insere_d   = 1'b0;
`ifdef FILTRO_BCD_EN
    invalido_d = 1'b0;
    if (aceita) begin
      if (chaves_sinc_q > 4'd9) begin
        invalido_d = 1'b1;
      end else begin
        numero_d   = chaves_sinc_q;
        insere_d   = 1'b1;
      end
    end
`else
    if (aceita) begin
      numero_d = chaves_sinc_q;
      insere_d = 1'b1;
    end
`endif
  end

  // State and registered outputs; reset lands in release filtering so a held button cannot fire
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= FILTRANDO_SOLTA;
      cnt_q      <= '0;
      numero_q   <= 4'd0;
      insere_q   <= 1'b0;
`ifdef FILTRO_BCD_EN
      invalido_q <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      numero_q   <= numero_d;
      insere_q   <= insere_d;
`ifdef FILTRO_BCD_EN
      invalido_q <= invalido_d;
`endif
    end
  end

  assign numero = numero_q;
  assign insere = insere_q;
`ifdef FILTRO_BCD_EN
  assign digitoInvalido = invalido_q;
`else
  assign digitoInvalido = 1'b0;
`endif

endmodule

// File: tb/tb_captura_digito.sv
// tb/tb_captura_digito.sv - self-checking bench for captura_digito against a run-length debounce model
module tb_captura_digito;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] chaves;
  logic       botao;
  logic [3:0] numero;
  logic       insere;
  logic       digitoInvalido;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int npulse = 0;
  int ninv = 0;
  int first_ins = -1;
  int t0;

  // reference model: input history plus debounced level and run length
  logic       m_s1b, m_s2b;
  logic [3:0] m_s1c, m_s2c;
  logic       m_db;
  int         m_run;
  logic [3:0] m_num;
  logic       m_ins, m_inv;

  captura_digito #(.DEBOUNCE_CICLOS(D)) dut (
    .clk(clk), .reset(reset), .chaves(chaves), .botao(botao),
    .numero(numero), .insere(insere), .digitoInvalido(digitoInvalido)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_s1b = 0; m_s2b = 0; m_s1c = 0; m_s2c = 0;
      m_db = 1; m_run = 0; m_num = 0; m_ins = 0; m_inv = 0;
    end else begin
      m_ins = 0; m_inv = 0;
      if (m_s2b != m_db) begin
        m_run++;
        if (m_run == D) begin
          m_db = m_s2b;
          m_run = 0;
          if (m_db) begin
`ifdef FILTRO_BCD_EN
            if (m_s2c > 9) m_inv = 1;
            else begin m_num = m_s2c; m_ins = 1; end
`else
            m_num = m_s2c; m_ins = 1;
`endif
          end
        end
      end else begin
        m_run = 0;
      end
      m_s2b = m_s1b; m_s1b = botao;
      m_s2c = m_s1c; m_s1c = chaves;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    chk("numero", numero, m_num);
    chk("insere", insere, m_ins);
    chk("digitoInvalido", digitoInvalido, m_inv);
    chk("excl", insere & digitoInvalido, 0);
    if (insere === 1'b1) begin
      npulse++;
      if (first_ins < 0) first_ins = cyc;
    end
    if (digitoInvalido === 1'b1) ninv++;
  endtask

  task automatic hold(input logic b, input int n);
    botao = b;
    repeat (n) step();
  endtask

  initial begin
    reset = 1; botao = 0; chaves = 0;
    step(); step();
    chk("reset_numero", numero, 0);
    chk("reset_insere", insere, 0);
    reset = 0;
    hold(0, 6);

    // clean press of 5
    chaves = 5; npulse = 0; first_ins = -1; t0 = cyc + 1;
    hold(1, 20);
    chk("clean_pulses", npulse, 1);
    chk("clean_latency", first_ins - t0, D + 1);
    chk("clean_numero", numero, 5);
    hold(0, 8);
    chk("clean_held", numero, 5);

    // press bounce
    chaves = 7; npulse = 0;
    hold(1, 1); hold(1, 1); hold(0, 1); hold(1, 1); hold(1, 1); hold(0, 1); hold(1, 1);
    chk("bounce_none", npulse, 0);
    hold(1, 10);
    chk("bounce_one", npulse, 1);
    chk("bounce_numero", numero, 7);
    hold(0, 8);

    // release bounce
    chaves = 2; hold(1, 8);
    npulse = 0;
    hold(0, 1); hold(0, 1); hold(1, 1); hold(1, 1); hold(0, 8);
    chk("rel_bounce_none", npulse, 0);
    chaves = 9; hold(1, 8);
    chk("rel_next_one", npulse, 1);
    chk("rel_next_numero", numero, 9);
    hold(0, 8);

    // switches change while held
    chaves = 6; hold(1, 8);
    chaves = 3; hold(1, 6);
    chk("hold_numero", numero, 6);
    hold(0, 8);
    chk("hold_after_release", numero, 6);
    hold(1, 8);
    chk("hold_next_press", numero, 3);
    hold(0, 8);

    // button held through reset
    botao = 1; chaves = 4; reset = 1;
    step(); step();
    reset = 0; npulse = 0;
    hold(1, 10);
    chk("rst_held_none", npulse, 0);
    chaves = 0;
    hold(0, 5);
    hold(1, 8);
    chk("rst_then_one", npulse, 1);
    chk("rst_then_numero", numero, 0);
    hold(0, 8);

    // out-of-range digit
    chaves = 12; npulse = 0; ninv = 0;
    hold(1, 8);
`ifdef FILTRO_BCD_EN
    chk("bcd_inv", ninv, 1);
    chk("bcd_ins", npulse, 0);
    chk("bcd_numero", numero, 0);
`else
    chk("bcd_ins", npulse, 1);
    chk("bcd_inv", ninv, 0);
    chk("bcd_numero", numero, 12);
`endif
    hold(0, 8);

    // randomized bouncing presses with occasional reset
    for (int i = 0; i < 400; i++) begin
      chaves = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) begin
        reset = 1; step(); reset = 0;
      end
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/captura_digito.md
CAPTURA_DIGITO -- requirements
Module: captura_digito

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CICLOS, 4, consecutive synchronized samples required to accept a press or a release; legal range 2..255.
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: chaves  input  4  raw, asynchronous digit switches.
REQ-005 SHALL have port: botao  input  1  raw, asynchronous, bouncing "insert" push-button; 1 = pressed.
REQ-006 SHALL have port: numero  output  4  registered digit captured at the last accepted press; feeds the code-checking FSM `numero` input.
REQ-007 SHALL have port: insere  output  1  registered one-cycle pulse per accepted press; feeds the code-checking FSM `insere` input.
REQ-008 SHALL have port: digitoInvalido  output  1  registered one-cycle pulse when a press is rejected (see Configuration).

Function
REQ-009 SHALL pass botao and chaves through 2-flop synchronizers (botaoSinc, chavesSinc) before any use.
REQ-010 SHALL implement FSM states OCIOSO, FILTRANDO_PRESS, PRESSIONADO, FILTRANDO_SOLTA, plus a counter of width ceil(log2(DEBOUNCE_CICLOS+1)).
REQ-011 SHALL, in OCIOSO: on botaoSinc=1, go to FILTRANDO_PRESS with counter=1; otherwise stay with counter=0.
REQ-012 SHALL, in FILTRANDO_PRESS: on botaoSinc=0, go to OCIOSO and clear counter; on botaoSinc=1 with counter=DEBOUNCE_CICLOS-1, accept the press and go to PRESSIONADO; otherwise increment counter.
REQ-013 SHALL, on acceptance, load numero<=chavesSinc and set insere<=1 at the same edge, so insere is high for exactly the first cycle in PRESSIONADO.
REQ-014 SHALL give press latency of DEBOUNCE_CICLOS+1 rising edges, counted from the edge at which botao=1 is first sampled to the edge at which insere rises.
REQ-015 SHALL, in PRESSIONADO: on botaoSinc=0, go to FILTRANDO_SOLTA with counter=1; otherwise stay.
REQ-016 SHALL, in FILTRANDO_SOLTA: on botaoSinc=1, return to PRESSIONADO, clear counter and not pulse; on botaoSinc=0 with counter=DEBOUNCE_CICLOS-1, go to OCIOSO; otherwise increment counter.
REQ-017 SHALL generate at most one insere pulse per physical press, regardless of how long the button is held or how it bounces.
REQ-018 SHALL hold numero unchanged between accepted presses, even when chaves changes while the button is held.
REQ-019 SHALL force insere and digitoInvalido to 0 on every cycle without an acceptance event; they SHALL never both be 1.

Reset
REQ-020 SHALL, when reset=1 at a clock edge, clear synchronizers, counter, numero=0, insere=0 and digitoInvalido=0, and enter FILTRANDO_SOLTA with counter=0.
REQ-021 SHALL, because of REQ-020, accept no press after reset until botaoSinc has been 0 for DEBOUNCE_CICLOS consecutive samples; a button held through reset release SHALL NOT produce a pulse.
REQ-022 SHALL give reset priority over all other events; reset asserted mid-filter SHALL discard the pending press.

Configuration
REQ-023 SHALL provide macro FILTRO_BCD_EN. When defined: an acceptance with chavesSinc>9 SHALL leave numero unchanged, keep insere=0 and pulse digitoInvalido for one cycle; the FSM still goes to PRESSIONADO. When undefined: values 0..15 SHALL all be accepted and digitoInvalido SHALL be tied to 0.

Verification (DEBOUNCE_CICLOS=4, 10 ns clock)
REQ-024 SHALL cover clean press: chaves=5, botao held 20 cycles -> exactly one insere pulse 5 edges after first sampling, numero=5 and held.
REQ-025 SHALL cover press bounce: botao 1,1,0,1,1,0,1 (one cycle each) -> no insere; then 1 held for 10 cycles -> exactly one insere pulse.
REQ-026 SHALL cover release bounce: press accepted, then botao 0,0,1,1,0 held low -> no second insere; the next clean press of digit 9 -> one pulse, numero=9.
REQ-027 SHALL cover switch change during hold: accept digit 6, change chaves to 3 while held -> numero stays 6 until the next accepted press.
REQ-028 SHALL cover held through reset: botao=1 during reset and after release -> no pulse; release for at least 4 cycles, then press digit 0 -> one pulse, numero=0.
REQ-029 SHALL cover the configuration macro: chaves=12 press with FILTRO_BCD_EN -> digitoInvalido pulse, insere=0, numero unchanged; without the macro -> insere pulse, numero=12.
